// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared types and constants for the tetromino fetch path.
//               Holds the fetch FSM state encoding, the BRAM word field
//               layout, the default piece count and the piece id constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

  // Fetch FSM state encoding (explicit 3-bit width)
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_ROTATE  = 3'd3,
    ST_DONE    = 3'd4
  } fetch_state_e;

  // BRAM word layout: [15:0] shape, [23:16] color, upper bits ignored
  localparam int SHAPE_LSB = 0;
  localparam int SHAPE_W   = 16;
  localparam int COLOR_LSB = 16;
  localparam int COLOR_W   = 8;

  // Request field widths
  localparam int PIECE_W = 3;
  localparam int ROT_W   = 2;

  // Number of valid piece ids (0..NUM_PIECES_DEFAULT-1)
  localparam int NUM_PIECES_DEFAULT = 7;

  // Piece ids, also the BRAM addresses of their words
  localparam logic [PIECE_W-1:0] PIECE_I = 3'd0;
  localparam logic [PIECE_W-1:0] PIECE_O = 3'd1;
  localparam logic [PIECE_W-1:0] PIECE_T = 3'd2;
  localparam logic [PIECE_W-1:0] PIECE_S = 3'd3;
  localparam logic [PIECE_W-1:0] PIECE_Z = 3'd4;
  localparam logic [PIECE_W-1:0] PIECE_J = 3'd5;
  localparam logic [PIECE_W-1:0] PIECE_L = 3'd6;

endpackage : tetris_pkg
`default_nettype wire

// File: rtl/tetromino_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : tetromino_fetch_if
// Description : Request/response handshake between game_logic_core (master)
//               and tetromino_fetch (slave).
// Signals     : req_valid/req_ready/req_piece/req_rot  - piece request
//               rsp_valid/rsp_ready/rsp_shape/rsp_color/rsp_err - response
// Revision    : 1.0 - initial release
// ============================================================================
interface tetromino_fetch_if;
  import tetris_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [PIECE_W-1:0] req_piece;
  logic [ROT_W-1:0]   req_rot;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [SHAPE_W-1:0] rsp_shape;
  logic [COLOR_W-1:0] rsp_color;
  logic               rsp_err;

  // Requester side (game_logic_core)
  modport master (
    output req_valid, req_piece, req_rot, rsp_ready,
    input  req_ready, rsp_valid, rsp_shape, rsp_color, rsp_err
  );

  // Fetch engine side
  modport slave (
    input  req_valid, req_piece, req_rot, rsp_ready,
    output req_ready, rsp_valid, rsp_shape, rsp_color, rsp_err
  );

endinterface : tetromino_fetch_if
`default_nettype wire

// File: rtl/tetromino_rot90.sv
`default_nettype none
// ============================================================================
// Module      : tetromino_rot90
// Description : Combinational 90-degree clockwise rotation of a 4x4 mask.
//               Bit index = row*4 + col; new[r][c] = old[3-c][r].
//               Shared with game_logic_core for collision checks.
// Ports       : i_shape [15:0] - input mask
//               o_shape [15:0] - rotated mask
// Revision    : 1.0 - initial release
// ============================================================================
module tetromino_rot90 (
  input  wire logic [15:0] i_shape,
  output logic      [15:0] o_shape
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign o_shape[r*4 + c] = i_shape[(3-c)*4 + r];
    end
  end

endmodule : tetromino_rot90
`default_nettype wire

// File: rtl/tetromino_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tetromino_fetch
// Description : Read-side client of the tetromino BRAM (port 0). Accepts a
//               piece request, reads the piece word, rotates the 4x4 shape
//               clockwise rot times (one step per cycle) and returns shape
//               and color over a valid/ready handshake.
// Macro       : TETROMINO_FETCH_ERRCHK_EN - when defined, ids >= NUM_PIECES
//               skip the BRAM and respond with rsp_err=1, shape=0, color=0.
//               When undefined every id is read and rsp_err is 0.
// Ports       : clk, reset_n (async, active-low)
//               bus   - tetromino_fetch_if.slave request/response
//               addr0, ce0, we0, d0, q0 - BRAM port 0 (read only)
// Revision    : 1.0 - initial release
// ============================================================================
module tetromino_fetch
  import tetris_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 4,
  parameter int NUM_PIECES = NUM_PIECES_DEFAULT
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  tetromino_fetch_if.slave       bus,
  output logic      [AWIDTH-1:0] addr0,
  output logic                   ce0,
  output logic                   we0,
  output logic      [DWIDTH-1:0] d0,
  input  wire logic [DWIDTH-1:0] q0
);

  fetch_state_e        state_q, state_d;
  logic [PIECE_W-1:0]  piece_q, piece_d;
  logic [ROT_W-1:0]    rot_q,   rot_d;
  logic [ROT_W-1:0]    cnt_q,   cnt_d;
  logic [SHAPE_W-1:0]  shape_q, shape_d;
  logic [COLOR_W-1:0]  color_q, color_d;
  logic                err_q,   err_d;

  logic [SHAPE_W-1:0]  shape_rot;
  logic                accept;
  logic                piece_bad;

  assign accept = (state_q == ST_IDLE) && bus.req_valid;

`ifdef TETROMINO_FETCH_ERRCHK_EN
  assign piece_bad = (int'(bus.req_piece) >= NUM_PIECES);
`else
  assign piece_bad = 1'b0;
`endif

  // Upper word bits carry no information for this block
  if (DWIDTH > 24) begin : g_q0_hi
    logic unused_q0_hi;
    assign unused_q0_hi = ^q0[DWIDTH-1:24];
  end

  tetromino_rot90 u_rot90 (
    .i_shape (shape_q),
    .o_shape (shape_rot)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d = piece_bad ? ST_DONE : ST_READ;
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = (rot_q != '0) ? ST_ROTATE : ST_DONE;
      ST_ROTATE: begin
        // Counter still holds the pre-decrement value: last step when it is 1
        if (cnt_q == 2'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    ce0           = 1'b0;
    addr0         = '0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: bus.req_ready = 1'b1;
      ST_READ: begin
        ce0   = 1'b1;
        addr0 = AWIDTH'(piece_q);
      end
      ST_DONE: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign we0           = 1'b0;
  assign d0            = '0;
  assign bus.rsp_shape = shape_q;
  assign bus.rsp_color = color_q;
  assign bus.rsp_err   = err_q;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_comb begin
    piece_d = piece_q;
    rot_d   = rot_q;
    cnt_d   = cnt_q;
    shape_d = shape_q;
    color_d = color_q;
    err_d   = err_q;

    if (accept) begin
      // Request fields are only sampled here; clear the previous response so
      // an error response carries shape=0 and color=0.
      piece_d = bus.req_piece;
      rot_d   = bus.req_rot;
      shape_d = '0;
      color_d = '0;
      err_d   = piece_bad;
    end else if (state_q == ST_CAPTURE) begin
      shape_d = q0[SHAPE_LSB +: SHAPE_W];
      color_d = q0[COLOR_LSB +: COLOR_W];
      cnt_d   = rot_q;
    end else if (state_q == ST_ROTATE) begin
      shape_d = shape_rot;
      cnt_d   = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      piece_q <= '0;
      rot_q   <= '0;
      cnt_q   <= '0;
      shape_q <= '0;
      color_q <= '0;
      err_q   <= 1'b0;
    end else begin
      piece_q <= piece_d;
      rot_q   <= rot_d;
      cnt_q   <= cnt_d;
      shape_q <= shape_d;
      color_q <= color_d;
      err_q   <= err_d;
    end
  end

endmodule : tetromino_fetch
`default_nettype wire

// File: tb/tb_tetromino_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_tetromino_fetch
// Description : Directed self-checking bench for tetromino_fetch. Models the
//               BRAM port 0 read (data valid the cycle after ce0) and checks
//               latency, BRAM access, shape/color/err, backpressure and
//               asynchronous reset against hand-computed values.
// Macro       : TETROMINO_FETCH_ERRCHK_EN selects the piece-7 expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tetromino_fetch;
  import tetris_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] addr0;
  logic          ce0;
  logic          we0;
  logic [DW-1:0] d0;
  logic [DW-1:0] q0 = '0;
  logic [DW-1:0] mem [0:15];

  int n_cmp  = 0;
  int n_mis  = 0;
  int ce_cnt = 0;

  tetromino_fetch_if bus ();

  tetromino_fetch #(
    .DWIDTH     (DW),
    .AWIDTH     (AW),
    .NUM_PIECES (7)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .addr0   (addr0),
    .ce0     (ce0),
    .we0     (we0),
    .d0      (d0),
    .q0      (q0)
  );

  always #5 clk = ~clk;

  // BRAM port 0 model: registered read
  always @(posedge clk) begin
    if (ce0) begin
      q0     <= mem[addr0];
      ce_cnt <= ce_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request at the next edge and check the response. Called #1
  // after a rising edge with the DUT idle.
  task automatic do_req(input string tag, input logic [2:0] piece, input logic [1:0] rot,
                        input int exp_lat, input logic [15:0] exp_shape,
                        input logic [7:0] exp_color, input logic exp_err,
                        input bit exp_read, input bit do_ack);
    int            lat;
    int            ce_at;
    int            ce_before;
    logic [AW-1:0] ce_addr;
    lat     = -1;
    ce_at   = -1;
    ce_addr = '0;
    check_eq({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_piece = piece;
    bus.req_rot   = rot;
    @(posedge clk); #1;                 // accept edge T, now in cycle T+1
    ce_before     = ce_cnt;
    bus.req_valid = 1'b0;
    bus.req_piece = ~piece;             // later changes must be ignored
    bus.req_rot   = ~rot;
    for (int k = 1; k <= 10; k++) begin
      if (ce0 && ce_at < 0) begin
        ce_at   = k;
        ce_addr = addr0;
      end
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (exp_read) begin
      check_eq({tag, " ce0_cycle"}, 32'(ce_at), 32'd1);
      check_eq({tag, " addr0"}, 32'(ce_addr), 32'(piece));
    end else begin
      check_eq({tag, " ce0_pulses"}, 32'(ce_cnt - ce_before), 32'd0);
    end
    check_eq({tag, " shape"}, 32'(bus.rsp_shape), 32'(exp_shape));
    check_eq({tag, " color"}, 32'(bus.rsp_color), 32'(exp_color));
    check_eq({tag, " err"},   32'(bus.rsp_err),   32'(exp_err));
    if (do_ack) begin
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      check_eq({tag, " rsp_valid_after_ack"}, 32'(bus.rsp_valid), 32'd0);
      check_eq({tag, " req_ready_after_ack"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'h00E0_00F0;             // I piece
    mem[1] = 32'h001C_0660;             // O piece
    mem[2] = 32'hAB3C_04E0;             // T piece, junk in ignored bits
    mem[7] = 32'hFF5A_8421;

    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_piece = '0;
    bus.req_rot   = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst ce0",       32'(ce0),           32'd0);
    check_eq("rst addr0",     32'(addr0),         32'd0);
    check_eq("rst shape",     32'(bus.rsp_shape), 32'd0);
    check_eq("rst req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("we0",           32'(we0),           32'd0);
    check_eq("d0",            d0,                 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_req("i_rot0", 3'd0, 2'd0, 3, 16'h00F0, 8'hE0, 1'b0, 1'b1, 1'b1);
    do_req("i_rot1", 3'd0, 2'd1, 4, 16'h4444, 8'hE0, 1'b0, 1'b1, 1'b1);
    do_req("i_rot2", 3'd0, 2'd2, 5, 16'h0F00, 8'hE0, 1'b0, 1'b1, 1'b1);
    do_req("o_rot3", 3'd1, 2'd3, 6, 16'h0660, 8'h1C, 1'b0, 1'b1, 1'b1);
    do_req("t_rot1", 3'd2, 2'd1, 4, 16'h4640, 8'h3C, 1'b0, 1'b1, 1'b1);
`ifdef TETROMINO_FETCH_ERRCHK_EN
    do_req("id7_err", 3'd7, 2'd2, 1, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1);
`else
    do_req("id7_read", 3'd7, 2'd0, 3, 16'h8421, 8'h5A, 1'b0, 1'b1, 1'b1);
`endif

    // Backpressure: response held, new requests ignored
    do_req("hold", 3'd1, 2'd0, 3, 16'h0660, 8'h1C, 1'b0, 1'b1, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_piece = 3'd2;
    bus.req_rot   = 2'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_eq("hold rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold req_ready", 32'(bus.req_ready), 32'd0);
      check_eq("hold shape",     32'(bus.rsp_shape), 32'h0660);
      check_eq("hold color",     32'(bus.rsp_color), 32'h1C);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;                 // edge R
    bus.rsp_ready = 1'b0;
    do_req("after_hold", 3'd2, 2'd1, 4, 16'h4640, 8'h3C, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset while rotating
    bus.req_valid = 1'b1;
    bus.req_piece = 3'd1;
    bus.req_rot   = 2'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst shape", 32'(bus.rsp_shape), 32'h0660);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("mid_rst shape",     32'(bus.rsp_shape), 32'd0);
    check_eq("mid_rst color",     32'(bus.rsp_color), 32'd0);
    check_eq("mid_rst err",       32'(bus.rsp_err),   32'd0);
    check_eq("mid_rst ce0",       32'(ce0),           32'd0);
    check_eq("mid_rst addr0",     32'(addr0),         32'd0);
    check_eq("mid_rst req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_req("post_rst", 3'd0, 2'd1, 4, 16'h4444, 8'hE0, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_tetromino_fetch
`default_nettype wire

// File: doc/tetromino_fetch.md
# tetromino_fetch

Read-side client of the dual-port tetromino BRAM. It accepts a piece request (piece id and rotation) from game_logic_core and reads the piece's 32-bit shape/color word through BRAM port 0. It then rotates the 4x4 shape mask in 90° clockwise steps, one step per cycle, and returns shape and color over a valid/ready handshake. It sits between game_logic_core and port 0 of bram_tetromino. The AXI4-lite writer owns port 1.

## Interface
- DWIDTH, 32, BRAM word width (≥ 24)
- AWIDTH, 4, BRAM address width
- NUM_PIECES, 7, number of valid piece ids (0..NUM_PIECES-1)
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_piece  in  3  piece id, also the BRAM address
- req_rot  in  2  clockwise 90° steps, 0..3
- addr0  out  AWIDTH  BRAM port-0 address
- ce0  out  1  BRAM port-0 enable
- we0  out  1  tied 0
- d0  out  DWIDTH  tied 0
- q0  in  DWIDTH  BRAM read data, valid the cycle after ce0
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_shape  out  16  4x4 mask, bit index = row*4+col
- rsp_color  out  8  RGB332 color
- rsp_err  out  1  piece id out of range

## Operation
- Word layout: [15:0] shape, [23:16] color, [DWIDTH-1:24] ignored.
- States: IDLE, READ, CAPTURE, ROTATE, DONE.
- IDLE: when req_valid is high, latch piece and rot.
  - Valid piece id: go to READ.
  - Invalid id (≥ NUM_PIECES): go to DONE with rsp_err=1, shape=0, color=0. No BRAM access.
- READ: drive ce0=1 and addr0=piece for exactly one cycle. Go to CAPTURE.
- CAPTURE: latch q0 into the shape and color registers. Load the rotation counter from rot. Go to ROTATE if rot≠0, else DONE.
- ROTATE: each cycle, new[r][c] = old[3-c][r] and the counter decrements. When the counter reaches 0, go to DONE.
- DONE: rsp_valid=1 and outputs held stable. On rsp_ready, go to IDLE.
- ce0 is 0 in every state except READ. The block never writes the BRAM.
- Request fields are sampled only at the accept edge. Later changes are ignored.
- Reset, asynchronous and usable at any point:
  - state goes to IDLE
  - ce0, addr0, rsp_valid, rsp_shape, rsp_color, rsp_err all 0
  - req_ready = 1 once in IDLE
  - any in-flight request is dropped.

## Timing
- Accept at edge T (req_valid & req_ready).
- ce0 is high during cycle T+1. q0 is sampled in T+2.
- rsp_valid first rises in cycle T+3+rot, so latency is 3 to 6 cycles.
- Invalid id: rsp_valid rises in cycle T+1.
- Response handshake at edge R: req_ready is high in cycle R+1, and a new request can be accepted at that edge.
- rsp_valid stays high and the data stays stable until rsp_ready. rsp_ready has no effect outside DONE.

## Configuration
- TETROMINO_FETCH_ERRCHK_EN defined: range check is active and rsp_err behaves as described above.
- Undefined: no range check. Every id goes to READ with addr0 = zero-extended req_piece, and rsp_err is tied to 0. Address 7 is read as ordinary BRAM data.

## Structure
- tetris_pkg holds:
  - fetch state enum
  - word field constants: SHAPE_LSB=0, SHAPE_W=16, COLOR_LSB=16, COLOR_W=8
  - NUM_PIECES default
  - piece id constants, I=0, O=1, ...
- Sub-module tetromino_rot90: combinational 16-bit clockwise rotation. It is reused by game_logic_core for collision checks.

## Test plan
- BRAM[0]=0x00E000F0, request piece 0, rot 0 -> ce0 in T+1 with addr0=0; rsp at T+3 with shape 0x00F0, color 0xE0, err 0.
- Same word, rot 1 -> rsp at T+4 with shape 0x4444. rot 2 -> rsp at T+5 with shape 0x0F00.
- BRAM[1]=0x001C0660, rot 3 -> rsp at T+6 with shape 0x0660, color 0x1C.
- Piece 7 with ERRCHK_EN -> rsp at T+1 with err=1, shape 0, and ce0 never asserted. Without the macro -> BRAM[7] data is returned, err=0.
- Hold rsp_ready low for 5 cycles in DONE -> outputs stable, req_ready=0, req_valid ignored. Then rsp_ready=1 -> next request is accepted the following cycle.
- Assert reset_n low during ROTATE -> all outputs 0 immediately. After release, req_ready=1 and a fresh request completes correctly.
